if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage directly downstream of the PC register. Accepts PCs over a valid/ready
//   handshake and issues one instruction-bus read per PC (req/gnt, variable-latency rvalid).
//   Buffers {pc, instr, err} in an in-order FWFT FIFO toward decode; flush drops all in-flight work.
// PARAMETERS
//   ADDR_W      32  PC / bus address width
//   DATA_W      32  instruction width
//   FIFO_DEPTH  4   output FIFO entries, power of 2, >=2; also the max outstanding + buffered fetches
// PORTS
//   clk           in   1       clock, all state on posedge
//   rst_n         in   1       reset, synchronous, active-low
//   pc_valid_i    in   1       upstream PC valid
//   pc_i          in   ADDR_W  PC to fetch, word aligned
//   pc_ready_o    out  1       PC accepted when pc_valid_i & pc_ready_o
//   ibus_req_o    out  1       bus read request, registered
//   ibus_addr_o   out  ADDR_W  bus read address, registered
//   ibus_gnt_i    in   1       request granted this cycle
//   ibus_rvalid_i in   1       read data valid; responses return in grant order, >=1 cycle after gnt
//   ibus_rdata_i  in   DATA_W  read data
//   ibus_err_i    in   1       bus error, qualified by ibus_rvalid_i
//   flush_i       in   1       branch/exception redirect: discard everything in flight
//   id_valid_o    out  1       entry available to decode (FIFO not empty)
//   id_pc_o       out  ADDR_W  PC of head entry
//   id_instr_o    out  DATA_W  instruction of head entry
//   id_err_o      out  1       bus error of head entry
//   id_ready_i    in   1       decode pops head when id_valid_o & id_ready_i
// BEHAVIOUR
// - Reset: state IDLE; ibus_req_o=0, ibus_addr_o=0, id_valid_o=0, pc_ready_o=0;
//   outstanding=0, drop_cnt=0, pc queue and output FIFO empty.
// - Credits: credit_ok = (outstanding + fifo_count + ibus_req_o) < FIFO_DEPTH, so FIFO never overflows.
// - FSM:
//     IDLE:  pc_ready_o = credit_ok & ~flush_i. On accept, register req=1 / addr=pc_i -> REQ.
//     REQ:   req/addr held stable until ibus_gnt_i. On gnt: push PC into pc queue, outstanding++.
//            Same-cycle accept of next PC allowed: pc_ready_o = gnt & credit_ok & ~flush_i
//            (gnt->ready combinational). Accept -> stay REQ with new addr; else drop req -> IDLE.
//     DRAIN: pc_ready_o=0, req=0. drop_cnt-- per rvalid. Exit to IDLE when drop_cnt==0.
// - Response: on rvalid with drop_cnt==0, pop pc queue and push {pc, rdata, err} into FIFO.
//   rvalid with outstanding==0 is ignored.
// - outstanding: +1 on gnt, -1 on rvalid; both in the same cycle leave it unchanged.
// - Latency (min): PC accepted at cycle 0; req at 1 (gnt at 1); rvalid at 2; id_valid_o at 3.
//   Throughput is one fetch/cycle with gnt=1 and rvalid every cycle.
// - FIFO is FWFT. Push and pop in the same cycle keep the count. A pop when empty is ignored.
// - flush_i (highest priority, any state):
//     * Output FIFO and pc queue cleared; id_valid_o=0 next cycle.
//       A decode handshake in the flush cycle is void.
//     * drop_cnt <= outstanding + gnt - (rvalid & outstanding!=0).
//     * rvalid in the flush cycle is dropped.
//     * No PC accepted in the flush cycle.
//     * In REQ without gnt: req stays held (bus rule), kill flag set, state stays REQ.
//       On that later gnt: drop_cnt++, req=0, -> DRAIN.
//     * Otherwise: req=0; -> DRAIN if the computed drop_cnt != 0, else -> IDLE.
//     * A flush during DRAIN adds nothing new; the drain continues.
// - Reset mid-operation: everything returns to reset values next cycle.
//   Bus responses to pre-reset requests are ignored (outstanding=0).
// - ibus_err_i is passed through with its entry. The fetch unit does not stop on error; decode decides.
// TESTING
// 1 Single fetch, gnt=1, rvalid 1 cycle later, pc=0x0 data=0x00000013
//   -> id_valid_o at cycle 3 with id_pc_o=0, id_instr_o=0x00000013.
// 2 Stream pc=0,4,8,... with gnt=rvalid=1 and id_ready_i=1
//   -> one instr/cycle in order; id_pc_o increments by 4 each cycle.
// 3 id_ready_i=0 with FIFO_DEPTH=4 -> exactly 4 fetches issued, then pc_ready_o=0;
//   releasing id_ready_i resumes issue with no loss or duplication.
// 4 gnt delayed 3 cycles -> ibus_req_o/ibus_addr_o stable throughout; pc_ready_o=0 until gnt.
// 5 Flush with 2 outstanding -> those 2 rvalids are dropped and id_valid_o stays 0;
//   the next PC (0x100) is accepted only after the drain; id_pc_o=0x100 is the first output.
// 6 Flush in REQ before gnt, gnt 2 cycles later -> that response is dropped; then IDLE; no stale output.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: upstream PC handshake, instruction bus and decode-side FIFO port.
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              pc_valid_i;
  logic [ADDR_W-1:0] pc_i;
  logic              pc_ready_o;
  logic              ibus_req_o;
  logic [ADDR_W-1:0] ibus_addr_o;
  logic              ibus_gnt_i;
  logic              ibus_rvalid_i;
  logic [DATA_W-1:0] ibus_rdata_i;
  logic              ibus_err_i;
  logic              flush_i;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_instr_o;
  logic              id_err_o;
  logic              id_ready_i;

  modport master (
    input  pc_valid_i, pc_i, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, ibus_err_i,
           flush_i, id_ready_i,
    output pc_ready_o, ibus_req_o, ibus_addr_o, id_valid_o, id_pc_o, id_instr_o, id_err_o
  );

  modport slave (
    output pc_valid_i, pc_i, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, ibus_err_i,
           flush_i, id_ready_i,
    input  pc_ready_o, ibus_req_o, ibus_addr_o, id_valid_o, id_pc_o, id_instr_o, id_err_o
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one bus read per accepted PC, in-order FWFT buffer toward decode,
// flush discards everything in flight by counting off the responses still owed.
module if_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  if_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d, kill_q, kill_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  pcq_wr_q, pcq_rd_q, fifo_wr_q, fifo_rd_q;
  logic [ADDR_W-1:0] pcq_mem  [FIFO_DEPTH];
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic             flush, credit_ok, gnt_ok, rsp_ok, deliver, pcq_push, id_pop, pc_ready;
  logic [SUM_W-1:0] credit_sum;

  assign flush      = bus.flush_i;
  assign credit_sum = SUM_W'(outstanding_q) + SUM_W'(fifo_cnt_q) + SUM_W'(req_q);
  assign credit_ok  = credit_sum < SUM_W'(FIFO_DEPTH);
  assign gnt_ok     = req_q & bus.ibus_gnt_i;
  assign rsp_ok     = bus.ibus_rvalid_i & (outstanding_q != '0);
  assign deliver    = rsp_ok & (drop_q == '0) & ~flush;
  assign pcq_push   = gnt_ok & ~kill_q & ~flush;
  assign id_pop     = (fifo_cnt_q != '0) & bus.id_ready_i & ~flush;

  // While draining, every outstanding response is owed to the drop counter, so a flush
  // simply re-derives the count from outstanding.
  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(gnt_ok) - CNT_W'(rsp_ok);
    if (flush) drop_d = outstanding_d;
    else       drop_d = drop_q + CNT_W'(gnt_ok & kill_q) - CNT_W'(rsp_ok & (drop_q != '0));
    if (flush) fifo_cnt_d = '0;
    else       fifo_cnt_d = fifo_cnt_q + CNT_W'(deliver) - CNT_W'(id_pop);
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    kill_d   = kill_q;
    pc_ready = 1'b0;
    case (state_q)
      IDLE: begin
        pc_ready = credit_ok & ~flush;
        if (flush) begin
          state_d = (drop_d != '0) ? DRAIN : IDLE;
        end else if (bus.pc_valid_i && credit_ok) begin
          req_d   = 1'b1;
          addr_d  = bus.pc_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (kill_q) begin
          if (gnt_ok) begin
            req_d   = 1'b0;
            kill_d  = 1'b0;
            state_d = DRAIN;
          end
        end else if (flush) begin
          // An ungranted request must stay on the bus; its response is killed later.
          if (gnt_ok) begin
            req_d   = 1'b0;
            state_d = (drop_d != '0) ? DRAIN : IDLE;
          end else begin
            kill_d = 1'b1;
          end
        end else if (gnt_ok) begin
          pc_ready = credit_ok;
          if (bus.pc_valid_i && credit_ok) begin
            addr_d = bus.pc_i;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (drop_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      kill_q        <= 1'b0;
      addr_q        <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifo_cnt_q    <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      kill_q        <= kill_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifo_cnt_q    <= fifo_cnt_d;
      if (flush) begin
        pcq_wr_q  <= '0;
        pcq_rd_q  <= '0;
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (pcq_push) pcq_wr_q  <= pcq_wr_q + PTR_W'(1);
        if (deliver)  pcq_rd_q  <= pcq_rd_q + PTR_W'(1);
        if (deliver)  fifo_wr_q <= fifo_wr_q + PTR_W'(1);
        if (id_pop)   fifo_rd_q <= fifo_rd_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pcq_push) pcq_mem[pcq_wr_q] <= addr_q;
    if (deliver)  fifo_mem[fifo_wr_q] <= {pcq_mem[pcq_rd_q], bus.ibus_rdata_i, bus.ibus_err_i};
  end

  assign bus.pc_ready_o  = pc_ready & rst_n;
  assign bus.ibus_req_o  = req_q;
  assign bus.ibus_addr_o = addr_q;
  assign bus.id_valid_o  = fifo_cnt_q != '0;
  assign {bus.id_pc_o, bus.id_instr_o, bus.id_err_o} = fifo_mem[fifo_rd_q];
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle table for single fetch / delayed grant,
// bus-responder sequences for streaming, backpressure and flush corners.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic pv; logic [31:0] pc; logic gnt; logic rv; logic [31:0] rdata; logic err; logic fl; logic idr;
    logic prdy; logic req; logic [31:0] addr; logic idv; logic [31:0] idpc; logic [31:0] idinstr; logic iderr;
  } vec_t;

  vec_t        vecs[16];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] rsp_q[$];
  logic [31:0] exp_q[$];
  int          drop_left, acc_cnt, gnt_cnt, out_cnt;
  bit          killed, rsp_en;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.pc_valid_i = 1'b0; bus.pc_i = '0; bus.ibus_gnt_i = 1'b0; bus.ibus_rvalid_i = 1'b0;
    bus.ibus_rdata_i = '0; bus.ibus_err_i = 1'b0; bus.flush_i = 1'b0; bus.id_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.pc_valid_i = 1'b1; bus.pc_i = 32'h123;
    rsp_en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_ready", 32'(bus.pc_ready_o), 32'd0);
    chk("rst_req",   32'(bus.ibus_req_o), 32'd0);
    chk("rst_addr",  bus.ibus_addr_o,     32'd0);
    chk("rst_idv",   32'(bus.id_valid_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_inputs();
    rsp_q.delete(); exp_q.delete();
    drop_left = 0; killed = 1'b0;
    acc_cnt = 0; gnt_cnt = 0; out_cnt = 0;
  endtask

  // One clock with the responder model: returns #1 after the next posedge.
  task automatic cycle();
    int          pre_drop;
    bit          pre_kill;
    logic [31:0] a;
    pre_drop = drop_left;
    pre_kill = killed;
    if (rsp_en && rsp_q.size() > 0) begin
      a = rsp_q.pop_front();
      bus.ibus_rvalid_i = 1'b1; bus.ibus_rdata_i = instr_of(a); bus.ibus_err_i = 1'b0;
      if (drop_left > 0) drop_left--;
    end else begin
      bus.ibus_rvalid_i = 1'b0; bus.ibus_rdata_i = '0;
    end
    @(negedge clk);
    if (pre_drop > 0 || pre_kill) chk("drain_ready", 32'(bus.pc_ready_o), 32'd0);
    if (bus.ibus_req_o && bus.ibus_gnt_i) begin
      rsp_q.push_back(bus.ibus_addr_o);
      gnt_cnt++;
      if (killed) begin drop_left++; killed = 1'b0; end
    end
    if (bus.flush_i) begin
      chk("flush_ready", 32'(bus.pc_ready_o), 32'd0);
      exp_q.delete();
      drop_left = rsp_q.size();
      killed = bus.ibus_req_o && !bus.ibus_gnt_i;
    end else begin
      if (bus.pc_valid_i && bus.pc_ready_o) begin exp_q.push_back(bus.pc_i); acc_cnt++; end
      if (bus.id_valid_o && bus.id_ready_i) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL stale_out: got pc 0x%0h, expected no entry", bus.id_pc_o);
        end else begin
          a = exp_q.pop_front();
          chk("out_pc",    bus.id_pc_o,          a);
          chk("out_instr", bus.id_instr_o,       instr_of(a));
          chk("out_err",   32'(bus.id_err_o),    32'd0);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(int n, bit stream);
    for (int i = 0; i < n; i++) begin
      int a0;
      a0 = acc_cnt;
      cycle();
      if (acc_cnt != a0) begin
        if (stream) bus.pc_i = bus.pc_i + 32'd4;
        else        bus.pc_valid_i = 1'b0;
      end
    end
  endtask

  initial begin
    //         pv    pc          gnt   rv    rdata          err   fl    idr   prdy  req   addr        idv   idpc        idinstr        iderr
    vecs[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h13,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 32'h13,        1'b0};
    vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 32'h13,        1'b0};
    vecs[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hAAAA0001,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 32'h00, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'hBBBB0002,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 32'h40, 32'hAAAA0001, 1'b1};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 1'b1, 32'h40, 32'hAAAA0001, 1'b1};
    vecs[14] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 1'b1, 32'h44, 32'hBBBB0002, 1'b0};
    vecs[15] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b0, 32'h00, 32'h0,         1'b0};

    // Single fetch latency, then a 3-cycle grant delay with error passthrough.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.pc_valid_i = vecs[i].pv;  bus.pc_i = vecs[i].pc;
      bus.ibus_gnt_i = vecs[i].gnt; bus.ibus_rvalid_i = vecs[i].rv;
      bus.ibus_rdata_i = vecs[i].rdata; bus.ibus_err_i = vecs[i].err;
      bus.flush_i = vecs[i].fl; bus.id_ready_i = vecs[i].idr;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(bus.pc_ready_o), 32'(vecs[i].prdy));
      chk($sformatf("v%0d_req", i),   32'(bus.ibus_req_o), 32'(vecs[i].req));
      chk($sformatf("v%0d_addr", i),  bus.ibus_addr_o,     vecs[i].addr);
      chk($sformatf("v%0d_idv", i),   32'(bus.id_valid_o), 32'(vecs[i].idv));
      if (vecs[i].idv) begin
        chk($sformatf("v%0d_idpc", i),    bus.id_pc_o,        vecs[i].idpc);
        chk($sformatf("v%0d_idinstr", i), bus.id_instr_o,     vecs[i].idinstr);
        chk($sformatf("v%0d_iderr", i),   32'(bus.id_err_o),  32'(vecs[i].iderr));
      end
      @(posedge clk); #1;
    end

    // Full-rate stream.
    do_reset();
    bus.pc_valid_i = 1'b1; bus.pc_i = 32'h0; bus.ibus_gnt_i = 1'b1; bus.id_ready_i = 1'b1; rsp_en = 1'b1;
    run(20, 1'b1);
    chk("stream_out", 32'(out_cnt), 32'd17);
    chk("stream_acc", 32'(acc_cnt), 32'd20);
    bus.pc_valid_i = 1'b0;
    run(4, 1'b1);
    chk("stream_tail", 32'(out_cnt), 32'd20);
    chk("stream_empty", 32'(exp_q.size()), 32'd0);

    // Decode stalled: credits cap issue at FIFO_DEPTH.
    do_reset();
    bus.pc_valid_i = 1'b1; bus.pc_i = 32'h200; bus.ibus_gnt_i = 1'b1; bus.id_ready_i = 1'b0; rsp_en = 1'b1;
    run(10, 1'b1);
    chk("bp_grants", 32'(gnt_cnt), 32'd4);
    chk("bp_acc", 32'(acc_cnt), 32'd4);
    @(negedge clk);
    chk("bp_ready", 32'(bus.pc_ready_o), 32'd0);
    chk("bp_idv", 32'(bus.id_valid_o), 32'd1);
    @(posedge clk); #1;
    bus.id_ready_i = 1'b1;
    run(12, 1'b1);
    bus.pc_valid_i = 1'b0;
    run(8, 1'b1);
    chk("bp_nolose", 32'(out_cnt), 32'(acc_cnt));
    chk("bp_nodup", 32'(gnt_cnt), 32'(acc_cnt));
    chk("bp_empty", 32'(exp_q.size()), 32'd0);

    // Flush with two responses outstanding.
    do_reset();
    bus.ibus_gnt_i = 1'b1; bus.id_ready_i = 1'b1; rsp_en = 1'b0;
    bus.pc_valid_i = 1'b1; bus.pc_i = 32'h10; cycle();
    bus.pc_i = 32'h14; cycle();
    bus.pc_valid_i = 1'b0; cycle();
    chk("fl_outstanding", 32'(rsp_q.size()), 32'd2);
    bus.flush_i = 1'b1; bus.pc_valid_i = 1'b1; bus.pc_i = 32'h100; cycle();
    bus.flush_i = 1'b0;
    acc_cnt = 0; out_cnt = 0;
    run(2, 1'b0);
    rsp_en = 1'b1;
    run(10, 1'b0);
    chk("fl_acc", 32'(acc_cnt), 32'd1);
    chk("fl_out", 32'(out_cnt), 32'd1);
    chk("fl_drained", 32'(drop_left), 32'd0);

    // Flush while request waits for grant; grant arrives two cycles later.
    do_reset();
    bus.ibus_gnt_i = 1'b0; bus.id_ready_i = 1'b1; rsp_en = 1'b1;
    bus.pc_valid_i = 1'b1; bus.pc_i = 32'h300; cycle();
    bus.pc_valid_i = 1'b0; bus.flush_i = 1'b1; cycle();
    bus.flush_i = 1'b0;
    chk("kill_req_held", 32'(bus.ibus_req_o), 32'd1);
    chk("kill_addr_held", bus.ibus_addr_o, 32'h300);
    cycle();
    chk("kill_req_held2", 32'(bus.ibus_req_o), 32'd1);
    bus.ibus_gnt_i = 1'b1; cycle();
    chk("kill_req_drop", 32'(bus.ibus_req_o), 32'd0);
    cycle();
    acc_cnt = 0; out_cnt = 0;
    bus.pc_valid_i = 1'b1; bus.pc_i = 32'h400;
    run(8, 1'b0);
    chk("kill_acc", 32'(acc_cnt), 32'd1);
    chk("kill_out", 32'(out_cnt), 32'd1);
    chk("kill_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
